// File: rtl/schedule_sequencer_if.sv
// Table-write channel between the schedule programming logic (master) and schedule_sequencer (slave).
// The master holds wr_en high with stable fields until it sees the one-cycle wr_ack pulse.
interface schedule_sequencer_if #(
  parameter int g_temp_width = 7
);
  logic                    wr_en;
  logic [2:0]              wr_idx;
  logic                    wr_valid;
  logic [6:0]              wr_days;
  logic [4:0]              wr_hour;
  logic [5:0]              wr_min;
  logic [g_temp_width-1:0] wr_temp;
  logic                    wr_ack;

  modport master (
    output wr_en, wr_idx, wr_valid, wr_days, wr_hour, wr_min, wr_temp,
    input  wr_ack
  );

  modport slave (
    input  wr_en, wr_idx, wr_valid, wr_days, wr_hour, wr_min, wr_temp,
    output wr_ack
  );
endinterface

// File: rtl/schedule_sequencer.sv
// Weekly setpoint scheduler: rescans a small event table on every minute change and drives the active setpoint.
// Define SCHED_HOLD_EN to add the i_hold_n / o_hold ports that freeze setpoint updates.
module schedule_sequencer #(
  parameter int g_num_entries  = 4,
  parameter int g_temp_width   = 7,
  parameter int g_default_temp = 70
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [6:0]              i_day,
  input  logic [4:0]              i_hour,
  input  logic [5:0]              i_minute,
  input  logic                    i_set_time_n,
`ifdef SCHED_HOLD_EN
  input  logic                    i_hold_n,
  output logic                    o_hold,
`endif
  schedule_sequencer_if.slave     wr,
  output logic [g_temp_width-1:0] o_setpoint,
  output logic [2:0]              o_active_idx,
  output logic                    o_sched_valid,
  output logic                    o_change,
  output logic                    o_busy
);

  localparam logic [g_temp_width-1:0] DEFAULT_TEMP = g_temp_width'(g_default_temp);
  localparam logic [2:0]              LAST_IDX     = 3'(g_num_entries - 1);

  typedef enum logic [1:0] {IDLE, SNAP, SCAN, UPDATE} state_t;

  state_t                  state;
  logic                    tbl_valid [g_num_entries];
  logic [6:0]              tbl_days  [g_num_entries];
  logic [4:0]              tbl_hour  [g_num_entries];
  logic [5:0]              tbl_min   [g_num_entries];
  logic [g_temp_width-1:0] tbl_temp  [g_num_entries];

  logic [5:0] min_dly;
  logic       set_dly;
  logic       pending;
  logic [6:0] snap_day;
  logic [4:0] snap_hour;
  logic [5:0] snap_min;
  logic [2:0] scan_idx;
  logic       hit_found;
  logic [2:0] hit_idx;
  logic       cur_hit;
  logic       trig;
  logic       hold_ok;
  logic       hold_trig;

`ifdef SCHED_HOLD_EN
  assign hold_ok   = i_hold_n;
  assign hold_trig = i_hold_n && o_hold;
`else
  assign hold_ok   = 1'b1;
  assign hold_trig = 1'b0;
`endif

  // Minute ticks count only outside set mode; leaving set mode or releasing hold forces a rescan.
  assign trig = (i_set_time_n && (i_minute != min_dly)) ||
                (i_set_time_n && !set_dly) ||
                hold_trig;

  always_comb begin
    cur_hit = 1'b0;
    for (int k = 0; k < g_num_entries; k++) begin
      if (scan_idx == 3'(k)) begin
        cur_hit = tbl_valid[k] &&
                  ((tbl_days[k] & snap_day) != 7'd0) &&
                  (tbl_hour[k] == snap_hour) &&
                  (tbl_min[k] == snap_min);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      for (int k = 0; k < g_num_entries; k++) begin
        tbl_valid[k] <= 1'b0;
        tbl_days[k]  <= 7'd0;
        tbl_hour[k]  <= 5'd0;
        tbl_min[k]   <= 6'd0;
        tbl_temp[k]  <= '0;
      end
      min_dly       <= 6'd0;
      set_dly       <= 1'b1;
      pending       <= 1'b0;
      snap_day      <= 7'd0;
      snap_hour     <= 5'd0;
      snap_min      <= 6'd0;
      scan_idx      <= 3'd0;
      hit_found     <= 1'b0;
      hit_idx       <= 3'd0;
      wr.wr_ack     <= 1'b0;
      o_setpoint    <= DEFAULT_TEMP;
      o_active_idx  <= 3'd0;
      o_sched_valid <= 1'b0;
      o_change      <= 1'b0;
      o_busy        <= 1'b0;
`ifdef SCHED_HOLD_EN
      o_hold        <= 1'b0;
`endif
    end else begin
      min_dly   <= i_minute;
      set_dly   <= i_set_time_n;
      o_change  <= 1'b0;
      wr.wr_ack <= 1'b0;
`ifdef SCHED_HOLD_EN
      o_hold    <= ~i_hold_n;
`endif
      if (trig && (state != IDLE)) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          // The ack gate stops a still-held wr_en from being taken twice.
          if (wr.wr_en && !wr.wr_ack) begin
            for (int k = 0; k < g_num_entries; k++) begin
              if (wr.wr_idx == 3'(k)) begin
                tbl_valid[k] <= wr.wr_valid;
                tbl_days[k]  <= wr.wr_days;
                tbl_hour[k]  <= wr.wr_hour;
                tbl_min[k]   <= wr.wr_min;
                tbl_temp[k]  <= wr.wr_temp;
              end
            end
            wr.wr_ack <= 1'b1;
            pending   <= 1'b1;
          end else if (trig || pending) begin
            pending <= 1'b0;
            o_busy  <= 1'b1;
            state   <= SNAP;
          end
        end
        SNAP: begin
          snap_day  <= i_day;
          snap_hour <= i_hour;
          snap_min  <= i_minute;
          scan_idx  <= 3'd0;
          hit_found <= 1'b0;
          state     <= SCAN;
        end
        SCAN: begin
          // Later hits overwrite earlier ones so the highest index wins.
          if (cur_hit) begin
            hit_found <= 1'b1;
            hit_idx   <= scan_idx;
          end
          if (scan_idx == LAST_IDX) begin
            state <= UPDATE;
          end else begin
            scan_idx <= scan_idx + 3'd1;
          end
        end
        UPDATE: begin
          if (hit_found && hold_ok) begin
            o_setpoint    <= tbl_temp[hit_idx[$clog2(g_num_entries > 1 ? g_num_entries : 2)-1:0]];
            o_active_idx  <= hit_idx;
            o_sched_valid <= 1'b1;
            o_change      <= 1'b1;
          end
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_schedule_sequencer.sv
// Randomized bench for schedule_sequencer against a table-lookup reference model.
// Directed phases cover latency, priority, set mode, busy writes and reset mid-scan.
module tb_schedule_sequencer;

  localparam int N  = 4;
  localparam int TW = 7;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic [6:0]    i_day;
  logic [4:0]    i_hour;
  logic [5:0]    i_minute;
  logic          i_set_time_n;
  logic [TW-1:0] o_setpoint;
  logic [2:0]    o_active_idx;
  logic          o_sched_valid;
  logic          o_change;
  logic          o_busy;
`ifdef SCHED_HOLD_EN
  logic          i_hold_n;
  logic          o_hold;
`endif

  schedule_sequencer_if #(.g_temp_width(TW)) wr_if ();

  schedule_sequencer #(
    .g_num_entries (N),
    .g_temp_width  (TW),
    .g_default_temp(70)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_day        (i_day),
    .i_hour       (i_hour),
    .i_minute     (i_minute),
    .i_set_time_n (i_set_time_n),
`ifdef SCHED_HOLD_EN
    .i_hold_n     (i_hold_n),
    .o_hold       (o_hold),
`endif
    .wr           (wr_if.slave),
    .o_setpoint   (o_setpoint),
    .o_active_idx (o_active_idx),
    .o_sched_valid(o_sched_valid),
    .o_change     (o_change),
    .o_busy       (o_busy)
  );

  always #25 i_clk = ~i_clk;

  int   compared   = 0;
  int   mismatched = 0;
  int   change_cnt = 0;
  int   scan_cnt   = 0;
  logic busy_prev  = 1'b0;

  // Reference model: the programmed table, the current time and the expected outputs.
  bit m_valid [8];
  int m_days  [8];
  int m_hour  [8];
  int m_min   [8];
  int m_temp  [8];
  int cur_d, cur_h, cur_m;
  int exp_sp, exp_idx, exp_valid;

  always @(posedge i_clk) begin
    #1;
    if (o_change) change_cnt++;
    if (o_busy && !busy_prev) scan_cnt++;
    busy_prev = o_busy;
  end

  task automatic check_output(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) begin
      m_valid[k] = 1'b0;
      m_days[k]  = 0;
      m_hour[k]  = 0;
      m_min[k]   = 0;
      m_temp[k]  = 0;
    end
    exp_sp    = 70;
    exp_idx   = 0;
    exp_valid = 0;
  endfunction

  // Highest-index entry whose day mask, hour and minute all match now, or -1.
  function automatic int model_match();
    for (int k = N - 1; k >= 0; k--) begin
      if (m_valid[k] && ((m_days[k] & (1 << cur_d)) != 0) &&
          m_hour[k] == cur_h && m_min[k] == cur_m)
        return k;
    end
    return -1;
  endfunction

  function automatic bit model_rescan();
    int k;
    k = model_match();
    if (k >= 0) begin
      exp_sp    = m_temp[k];
      exp_idx   = k;
      exp_valid = 1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic set_time(input int d, input int h, input int m);
    @(negedge i_clk);
    i_day    = 7'(1 << d);
    i_hour   = 5'(h);
    i_minute = 6'(m);
    cur_d = d;
    cur_h = h;
    cur_m = m;
  endtask

  task automatic apply_stimulus(input int idx, input int v, input int days, input int h,
                                input int m, input int t, output int ack_wait);
    int got;
    got      = 0;
    ack_wait = 0;
    @(negedge i_clk);
    wr_if.wr_en    = 1'b1;
    wr_if.wr_idx   = 3'(idx);
    wr_if.wr_valid = v[0];
    wr_if.wr_days  = 7'(days);
    wr_if.wr_hour  = 5'(h);
    wr_if.wr_min   = 6'(m);
    wr_if.wr_temp  = TW'(t);
    for (int i = 1; i <= 100 && got == 0; i++) begin
      @(posedge i_clk);
      #1;
      if (wr_if.wr_ack) begin
        got      = 1;
        ack_wait = i;
      end
    end
    check_output("wr_ack", got, 1);
    @(negedge i_clk);
    wr_if.wr_en = 1'b0;
    @(posedge i_clk);
    #1;
    check_output("wr_ack_pulse", int'(wr_if.wr_ack), 0);
    if (got == 1 && idx < N) begin
      m_valid[idx] = v[0];
      m_days[idx]  = days;
      m_hour[idx]  = h;
      m_min[idx]   = m;
      m_temp[idx]  = t;
    end
  endtask

  task automatic wait_idle();
    int low;
    int n;
    low = 0;
    n   = 0;
    repeat (2) @(posedge i_clk);
    while (low < 4 && n < 400) begin
      @(posedge i_clk);
      #1;
      n++;
      if (!o_busy) low++;
      else low = 0;
    end
    check_output("idle_wait", low, 4);
  endtask

  task automatic op_check(input string tag, input int rescans, input int chg0);
    int exp_chg;
    wait_idle();
    exp_chg = 0;
    repeat (rescans) if (model_rescan()) exp_chg++;
    check_output({tag, "_setpoint"}, int'(o_setpoint), exp_sp);
    check_output({tag, "_idx"}, int'(o_active_idx), exp_idx);
    check_output({tag, "_valid"}, int'(o_sched_valid), exp_valid);
    check_output({tag, "_changes"}, change_cnt - chg0, exp_chg);
  endtask

  initial begin
    int chg0, sc0, aw, lat, nd, nh, nm;
    model_reset();
    i_reset_n      = 1'b0;
    i_day          = 7'h01;
    i_hour         = 5'd0;
    i_minute       = 6'd0;
    i_set_time_n   = 1'b1;
    cur_d = 0; cur_h = 0; cur_m = 0;
    wr_if.wr_en    = 1'b0;
    wr_if.wr_idx   = 3'd0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_days  = 7'd0;
    wr_if.wr_hour  = 5'd0;
    wr_if.wr_min   = 6'd0;
    wr_if.wr_temp  = '0;
`ifdef SCHED_HOLD_EN
    i_hold_n       = 1'b1;
`endif
    repeat (3) @(negedge i_clk);
    check_output("rst_setpoint", int'(o_setpoint), 70);
    check_output("rst_valid", int'(o_sched_valid), 0);
    check_output("rst_busy", int'(o_busy), 0);
    check_output("rst_change", int'(o_change), 0);
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check_output("post_rst_busy", int'(o_busy), 0);

    // Weekday 07:00 event; o_change lands g_num_entries + 2 edges after the trigger edge.
    chg0 = change_cnt;
    set_time(1, 6, 59);
    op_check("t2_pre", 1, chg0);
    chg0 = change_cnt;
    apply_stimulus(0, 1, 'h3E, 7, 0, 68, aw);
    op_check("t2_wr", 1, chg0);
    chg0 = change_cnt;
    set_time(1, 7, 0);
    lat = 0;
    for (int i = 1; i <= N + 10; i++) begin
      @(posedge i_clk);
      #1;
      if (o_change && lat == 0) lat = i;
    end
    check_output("t2_latency", lat, N + 3);
    op_check("t2", 1, chg0);

    // Two more matching entries: highest index takes priority.
    chg0 = change_cnt;
    apply_stimulus(1, 1, 'h02, 7, 0, 72, aw);
    op_check("t3_idx1", 1, chg0);
    chg0 = change_cnt;
    apply_stimulus(3, 1, 'h02, 7, 0, 65, aw);
    op_check("t3_idx3", 1, chg0);

    // Set mode suppresses minute scans; release forces exactly one.
    chg0 = change_cnt;
    set_time(1, 6, 59);
    op_check("t4_pre", 1, chg0);
    chg0 = change_cnt;
    apply_stimulus(1, 0, 'h02, 7, 0, 72, aw);
    op_check("t4_dis1", 1, chg0);
    chg0 = change_cnt;
    apply_stimulus(3, 0, 'h02, 7, 0, 65, aw);
    op_check("t4_dis3", 1, chg0);
    sc0 = scan_cnt;
    @(negedge i_clk);
    i_set_time_n = 1'b0;
    set_time(1, 7, 0);
    repeat (3) @(negedge i_clk);
    set_time(1, 7, 1);
    repeat (3) @(negedge i_clk);
    set_time(1, 7, 0);
    repeat (12) @(negedge i_clk);
    check_output("t4_setmode_scans", scan_cnt - sc0, 0);
    chg0 = change_cnt;
    i_set_time_n = 1'b1;
    op_check("t4_release", 1, chg0);
    check_output("t4_release_scans", scan_cnt - sc0, 1);

    // Write raised mid-scan waits for IDLE; out-of-range index is acked but ignored.
    chg0 = change_cnt;
    set_time(1, 7, 1);
    op_check("t5_pre", 1, chg0);
    chg0 = change_cnt;
    sc0  = scan_cnt;
    set_time(1, 7, 0);
    apply_stimulus(7, 1, 'h7F, 7, 0, 99, aw);
    check_output("t5_ack_after_scan", int'(aw > N + 1), 1);
    op_check("t5", 2, chg0);
    check_output("t5_scans", scan_cnt - sc0, 2);

    // Random writes and time changes.
    for (int it = 0; it < 40; it++) begin
      chg0 = change_cnt;
      if ($urandom_range(0, 2) == 0) begin
        apply_stimulus($urandom_range(0, 7), ($urandom_range(0, 3) != 0) ? 1 : 0,
                       $urandom_range(0, 127), $urandom_range(7, 8),
                       $urandom_range(0, 1), $urandom_range(50, 90), aw);
        op_check("rnd_wr", 1, chg0);
      end else begin
        nd = $urandom_range(0, 6);
        nh = $urandom_range(7, 8);
        nm = $urandom_range(0, 1);
        sc0 = (nm != cur_m) ? 1 : 0;
        set_time(nd, nh, nm);
        op_check("rnd_tm", sc0, chg0);
      end
    end

    // Reset asserted mid-scan returns to reset values immediately.
    set_time(cur_d, cur_h, (cur_m == 0) ? 1 : 0);
    repeat (3) @(negedge i_clk);
    check_output("t6_busy_before", int'(o_busy), 1);
    i_reset_n = 1'b0;
    #1;
    check_output("t6_setpoint", int'(o_setpoint), 70);
    check_output("t6_valid", int'(o_sched_valid), 0);
    check_output("t6_busy", int'(o_busy), 0);
    check_output("t6_idx", int'(o_active_idx), 0);
    model_reset();
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    chg0 = change_cnt;
    op_check("t6_after", 1, chg0);

`ifdef SCHED_HOLD_EN
    chg0 = change_cnt;
    set_time(0, 8, 0);
    op_check("hold_pre", 1, chg0);
    @(negedge i_clk);
    i_hold_n = 1'b0;
    chg0 = change_cnt;
    apply_stimulus(0, 1, 'h7F, 8, 1, 80, aw);
    op_check("hold_wr", 1, chg0);
    chg0 = change_cnt;
    set_time(0, 8, 1);
    op_check("hold_held", 0, chg0);
    check_output("hold_flag", int'(o_hold), 1);
    chg0 = change_cnt;
    @(negedge i_clk);
    i_hold_n = 1'b1;
    op_check("hold_release", 1, chg0);
    check_output("hold_flag_off", int'(o_hold), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
